// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for DIV/DIVU in the EX stage.
// The divider produces one quotient bit per clock by trial subtraction of the
// divisor from the partial remainder. Operands are reduced to magnitudes at
// accept, and the signs are reapplied when the last quotient bit is done.
//
// Handshake: EX raises start_i and holds it until it sees ready_o. While in
// END the result stays on result_o with ready_o=1. Dropping start_i in END
// returns the unit to FREE, and from the next cycle ready_o and result_o
// read 0. annul_i aborts an operation in progress, and END ignores it.
//
// result_o = {remainder, quotient}. div_by_zero_o records whether the most
// recently produced result came from a zero divisor.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               div_by_zero_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;   // divisor magnitude
  logic               sign1_q, sign1_d; // dividend sign at accept
  logic               sign2_q, sign2_d; // divisor sign at accept
  logic               sdiv_q, sdiv_d;   // signed operation latched at accept
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               dbz_q, dbz_d;

  logic               accept;
  logic               divisor_zero;
  logic [WIDTH-1:0]   op1_abs;
  logic [WIDTH-1:0]   op2_abs;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign accept       = start_i && !annul_i;
  assign divisor_zero = (opdata2_i == '0);

  // Operand magnitudes. Only signed operations take the absolute value.
  always_comb begin
    op1_abs = opdata1_i;
    op2_abs = opdata2_i;
    if (signed_div_i && opdata1_i[WIDTH-1]) op1_abs = (~opdata1_i) + ONE_W;
    if (signed_div_i && opdata2_i[WIDTH-1]) op2_abs = (~opdata2_i) + ONE_W;
  end

  // One restoring step and the final sign correction.
  // The partial remainder is always below the divisor, so a trial value that
  // is not negative fits in WIDTH bits and the top bit of diff is the borrow.
  always_comb begin
    trial   = {rem_q, quo_q[WIDTH-1]};
    diff    = trial - {1'b0, dvsr_q};
    quo_fix = quo_q;
    rem_fix = rem_q;
    if (sdiv_q && (sign1_q ^ sign2_q)) quo_fix = (~quo_q) + ONE_W;
    if (sdiv_q && sign1_q)             rem_fix = (~rem_q) + ONE_W;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FREE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FREE: begin
        if (accept) state_d = divisor_zero ? S_BYZERO : S_ON;
      end
      S_BYZERO: state_d = S_END;
      S_ON: begin
        if (annul_i)                 state_d = S_FREE;
        else if (cnt_q == CNT_LAST) state_d = S_END;
      end
      S_END: begin
        if (!start_i) state_d = S_FREE;
      end
      default: state_d = S_FREE;
    endcase
  end

  // Outputs. ready_o and result_o are driven only while the unit is in END.
  always_comb begin
    ready_o       = (state_q == S_END);
    result_o      = ready_o ? res_q : '0;
    div_by_zero_o = dbz_q;
  end

  // Datapath next values: latch at accept, shift in ON, record the result on exit.
  always_comb begin
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    sign1_d = sign1_q;
    sign2_d = sign2_q;
    sdiv_d  = sdiv_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_FREE: begin
        if (accept && !divisor_zero) begin
          cnt_d   = '0;
          quo_d   = op1_abs;
          rem_d   = '0;
          dvsr_d  = op2_abs;
          sign1_d = opdata1_i[WIDTH-1];
          sign2_d = opdata2_i[WIDTH-1];
          sdiv_d  = signed_div_i;
        end
      end
      S_BYZERO: begin
        res_d = '0;
        dbz_d = 1'b1;
      end
      S_ON: begin
        if (!annul_i) begin
          if (cnt_q != CNT_LAST) begin
            if (!diff[WIDTH]) begin
              rem_d = diff[WIDTH-1:0];
              quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_d = trial[WIDTH-1:0];
              quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + ONE_CNT;
          end else begin
            res_d = {rem_fix, quo_fix};
            dbz_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers. Reset clears everything and discards a divide in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
      sdiv_q  <= 1'b0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      sign1_q <= sign1_d;
      sign2_q <= sign2_d;
      sdiv_q  <= sdiv_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: bench for div_unit at WIDTH=32 and WIDTH=8. The expected
// quotient and remainder come from the language's own signed or unsigned
// integer / and % operators.
module tb_div_unit;

  // Clock and reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // sel picks which instance the tasks drive and observe: 0 = WIDTH 32, 1 = WIDTH 8.
  logic sel;

  logic        st32, an32, sg32;
  logic [31:0] a32, b32;
  logic [63:0] res32;
  logic        rdy32, dbz32;

  logic        st8, an8, sg8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic        rdy8, dbz8;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut32 (
    .clk(clk), .rst(rst), .signed_div_i(sg32), .opdata1_i(a32), .opdata2_i(b32),
    .start_i(st32), .annul_i(an32), .result_o(res32), .ready_o(rdy32),
    .div_by_zero_o(dbz32)
  );

  div_unit #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst), .signed_div_i(sg8), .opdata1_i(a8), .opdata2_i(b8),
    .start_i(st8), .annul_i(an8), .result_o(res8), .ready_o(rdy8),
    .div_by_zero_o(dbz8)
  );

  logic        obs_ready, obs_dbz;
  logic [63:0] obs_result;
  always_comb begin
    obs_ready  = sel ? rdy8 : rdy32;
    obs_dbz    = sel ? dbz8 : dbz32;
    obs_result = sel ? {48'd0, res8} : res32;
  end

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [63:0] exp_q[$];

  // Reference model: returns {remainder, quotient} for a w-bit operation.
  function automatic logic [63:0] model(int w, bit sgn, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] m;
    m  = (64'd1 << w) - 64'd1;
    sa = 0;
    sb = 0;
    sa[31:0] = a & m[31:0];
    sb[31:0] = b & m[31:0];
    if (sb == 0) return 64'd0;
    if (sgn) begin
      if (sa[w-1]) sa = sa - (longint'(1) << w);
      if (sb[w-1]) sb = sb - (longint'(1) << w);
    end
    q = sa / sb;
    r = sa % sb;
    return ((64'(r) & m) << w) | (64'(q) & m);
  endfunction

  // Driver tasks.
  task automatic drive(input logic st, input logic an, input logic sg,
                       input logic [31:0] a, input logic [31:0] b);
    if (sel) begin
      st8 = st; an8 = an; sg8 = sg; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      st32 = st; an32 = an; sg32 = sg; a32 = a; b32 = b;
    end
  endtask

  // Starts an operation at a falling edge and waits for ready_o. Operands are
  // scrambled after accept. Start is left high on return.
  task automatic do_op(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int w, lat, edges;
    logic [31:0] mask;
    logic [63:0] exp;
    bit exp_dbz;
    w    = sel ? 8 : 32;
    mask = sel ? 32'hFF : 32'hFFFF_FFFF;
    exp_dbz = ((b & mask) == 32'd0);
    lat  = exp_dbz ? 2 : w + 2;
    exp_q.push_back(model(w, sgn, a, b));
    drive(1'b1, 1'b0, sgn, a, b);
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (!obs_ready) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
    end while (!obs_ready && edges < 80);
    exp = exp_q.pop_front();
    total_cnt++;
    if (edges !== lat) $display("FAIL latency w=%0d a=%h b=%h: got %0d edges, want %0d", w, a, b, edges, lat);
    else pass_cnt++;
    total_cnt++;
    if (obs_result !== exp) $display("FAIL result w=%0d s=%0d a=%h b=%h: got %h, want %h", w, sgn, a, b, obs_result, exp);
    else pass_cnt++;
    total_cnt++;
    if (obs_dbz !== exp_dbz) $display("FAIL div_by_zero w=%0d b=%h: got %b, want %b", w, b, obs_dbz, exp_dbz);
    else pass_cnt++;
  endtask

  // Drops start and checks that ready_o and result_o clear one cycle later.
  task automatic end_op();
    drive(1'b0, 1'b0, 1'b0, $urandom, $urandom);
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (obs_ready !== 1'b0) $display("FAIL ready_after_drop sel=%0d: got %b, want 0", sel, obs_ready);
    else pass_cnt++;
    total_cnt++;
    if (obs_result !== 64'd0) $display("FAIL result_after_drop sel=%0d: got %h, want 0", sel, obs_result);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    st32 = 0; an32 = 0; sg32 = 0; a32 = 0; b32 = 0;
    st8 = 0; an8 = 0; sg8 = 0; a8 = 0; b8 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({rdy32, dbz32, res32} !== 66'd0) $display("FAIL reset_w32: got rdy=%b dbz=%b res=%h, want 0", rdy32, dbz32, res32);
    else pass_cnt++;
    total_cnt++;
    if ({rdy8, dbz8, res8} !== 18'd0) $display("FAIL reset_w8: got rdy=%b dbz=%b res=%h, want 0", rdy8, dbz8, res8);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] mn, all1, neg7, neg2;
    mn   = sel ? 32'h80 : 32'h8000_0000;
    all1 = sel ? 32'hFF : 32'hFFFF_FFFF;
    neg7 = sel ? 32'hF9 : 32'hFFFF_FFF9;
    neg2 = sel ? 32'hFE : 32'hFFFF_FFFE;
    do_op(0, 32'd7, 32'd2);   end_op();
    do_op(1, neg7, 32'd2);    end_op();
    do_op(1, 32'd7, neg2);    end_op();
    do_op(1, neg7, neg2);     end_op();
    do_op(0, 32'd5, 32'd0);   end_op();
    do_op(1, neg7, 32'd0);    end_op();
    do_op(1, mn, all1);       end_op();
    do_op(0, all1, 32'd1);    end_op();
    do_op(0, 32'd3, 32'd9);   end_op();
    do_op(0, all1, all1);     end_op();
  endtask

  // Fixed constants for the 32-bit cases, independent of the model.
  task automatic test_known_values();
    sel = 1'b0;
    do_op(0, 32'd7, 32'd2);
    total_cnt++;
    if (res32 !== {32'd1, 32'd3}) $display("FAIL divu_7_2: got %h, want %h", res32, {32'd1, 32'd3});
    else pass_cnt++;
    end_op();
    do_op(1, 32'hFFFF_FFF9, 32'd2);
    total_cnt++;
    if (res32 !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) $display("FAIL div_m7_2: got %h, want ffffffff_fffffffd", res32);
    else pass_cnt++;
    end_op();
    do_op(1, 32'h8000_0000, 32'hFFFF_FFFF);
    total_cnt++;
    if (res32 !== {32'd0, 32'h8000_0000}) $display("FAIL div_minneg: got %h, want 00000000_80000000", res32);
    else pass_cnt++;
    end_op();
  endtask

  task automatic test_random(input int n);
    logic [31:0] a, b;
    bit sg;
    for (int i = 0; i < n; i++) begin
      a  = $urandom;
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = {28'hFFFF_FFF, 4'($urandom_range(0, 15))};
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = sel ? 32'h80 : 32'h8000_0000;
      do_op(sg, a, b);
      end_op();
    end
  endtask

  task automatic test_annul();
    int rose;
    drive(1'b1, 1'b0, 1'b0, 32'd1000, 32'd3);
    repeat (11) @(posedge clk);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'd1000, 32'd3);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    rose = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (obs_ready) rose++;
    end
    total_cnt++;
    if (rose !== 0) $display("FAIL annul_no_ready sel=%0d: got %0d ready cycles, want 0", sel, rose);
    else pass_cnt++;
    do_op(0, 32'd100, 32'd7);
    total_cnt++;
    if (obs_result[15:0] !== (sel ? 16'h020E : 16'h000E)) $display("FAIL annul_restart sel=%0d: got %h, want q=14 r=2", sel, obs_result);
    else pass_cnt++;
    end_op();
  endtask

  task automatic test_hold_end();
    logic [63:0] held;
    int bad;
    do_op(1, 32'hFFFF_FF9C, 32'd7);
    held = obs_result;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      @(posedge clk);
      @(negedge clk);
      if (obs_ready !== 1'b1 || obs_result !== held) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL hold_end sel=%0d: got %0d unstable cycles, want 0", sel, bad);
    else pass_cnt++;
    end_op();
  endtask

  task automatic test_reset_mid();
    do_op(0, 32'd9, 32'd0);
    end_op();
    drive(1'b1, 1'b0, 1'b0, 32'd200, 32'd9);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if ({obs_ready, obs_dbz, obs_result} !== 66'd0)
      $display("FAIL reset_mid sel=%0d: got rdy=%b dbz=%b res=%h, want 0", sel, obs_ready, obs_dbz, obs_result);
    else pass_cnt++;
    do_op(0, 32'd200, 32'd9);
    end_op();
  endtask

  // Back-to-back: each op is started right at the cycle after FREE is re-entered.
  task automatic test_back_to_back();
    do_op(0, 32'd50, 32'd6);  end_op();
    do_op(1, 32'd50, 32'd0);  end_op();
    do_op(1, 32'hFFFF_FFCE, 32'd6); end_op();
  endtask

  initial begin
    sel = 1'b0;
    test_reset();
    test_known_values();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      test_directed();
      test_annul();
      test_hold_end();
      test_reset_mid();
      test_back_to_back();
      test_random(s == 0 ? 40 : 80);
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
